// File: rtl/ram_load_ctrl.sv
// ---------------------------------------------------------------------------
// ram_load_ctrl
// Loads 16 bytes from a valid/ready source into a 16x8 RAM, then reads them
// all back and compares the modulo-256 sums of written and read-back data.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   start      in   1  begin a load+verify pass (sampled only when idle)
//   abort      in   1  synchronous abort back to idle
//   wr_valid   in   1  source byte valid
//   wr_data    in   8  source byte
//   wr_ready   out  1  controller ready for a source byte
//   mar        out  4  RAM address
//   ram_wdata  out  8  RAM write data
//   ram_rdata  in   8  RAM read data
//   lr_n       out  1  active-low RAM load strobe
//   ce_n       out  1  active-low RAM output enable
//   busy       out  1  pass in progress
//   done       out  1  one-cycle pulse when verify completes
//   err        out  1  sticky checksum mismatch flag
//   wr_sum     out  8  modulo-256 sum of written bytes
//   rd_sum     out  8  modulo-256 sum of read-back bytes
// ---------------------------------------------------------------------------
module ram_load_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [3:0] mar,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       lr_n,
    output logic       ce_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] wr_sum,
    output logic [7:0] rd_sum
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_CMP  = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_mar;
    logic [AW-1:0] w_mar_nxt;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] w_wdata_nxt;
    logic [DW-1:0] r_wr_sum;
    logic [DW-1:0] w_wr_sum_nxt;
    logic [DW-1:0] r_rd_sum;
    logic [DW-1:0] w_rd_sum_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_last;

    logic          r_wr_ready;
    logic          r_lr_n;
    logic          r_ce_n;
    logic          r_busy;
    logic          r_done;

    assign w_last = (r_cnt == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mar    <= '0;
            r_wdata  <= '0;
            r_wr_sum <= '0;
            r_rd_sum <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mar    <= w_mar_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wr_sum <= w_wr_sum_nxt;
            r_rd_sum <= w_rd_sum_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and datapath update; abort freezes the datapath and idles
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mar_nxt    = r_mar;
        w_wdata_nxt  = r_wdata;
        w_wr_sum_nxt = r_wr_sum;
        w_rd_sum_nxt = r_rd_sum;
        w_err_nxt    = r_err;

        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt  = S_LOAD;
                        w_cnt_nxt    = '0;
                        w_wr_sum_nxt = '0;
                        w_rd_sum_nxt = '0;
                        w_err_nxt    = 1'b0;
                    end
                end
                S_LOAD: begin
                    // wr_ready is high exactly while in LOAD
                    if (wr_valid) begin
                        w_wdata_nxt  = wr_data;
                        w_mar_nxt    = r_cnt;
                        w_wr_sum_nxt = r_wr_sum + wr_data;
                        w_state_nxt  = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_mar_nxt   = '0;
                        w_state_nxt = S_RD_ADDR;
                    end else begin
                        w_cnt_nxt   = r_cnt + AW'(1);
                        w_state_nxt = S_LOAD;
                    end
                end
                S_RD_ADDR: begin
                    w_state_nxt = S_RD_CMP;
                end
                S_RD_CMP: begin
                    // Address was set up a full cycle earlier, so a registered RAM
                    // read is also valid by this edge
                    w_rd_sum_nxt = r_rd_sum + ram_rdata;
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_cnt_nxt   = r_cnt + AW'(1);
                        w_mar_nxt   = r_cnt + AW'(1);
                        w_state_nxt = S_RD_ADDR;
                    end
                end
                S_FIN: begin
                    w_err_nxt   = r_err | (r_wr_sum != r_rd_sum);
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Control outputs registered from the next state so they are glitch-free
    // and line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ready <= 1'b0;
            r_lr_n     <= 1'b1;
            r_ce_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_ready <= (w_state_nxt == S_LOAD);
            r_lr_n     <= (w_state_nxt != S_WRITE);
            r_ce_n     <= !((w_state_nxt == S_RD_ADDR) || (w_state_nxt == S_RD_CMP));
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_FIN);
        end
    end

    assign wr_ready  = r_wr_ready;
    assign mar       = r_mar;
    assign ram_wdata = r_wdata;
    assign lr_n      = r_lr_n;
    assign ce_n      = r_ce_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign wr_sum    = r_wr_sum;
    assign rd_sum    = r_rd_sum;

endmodule

// File: tb/tb_ram_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_load_ctrl
// Drives load+verify passes through ram_load_ctrl with an attached 16x8 RAM
// model and compares results against sums computed directly from the bytes.
// ---------------------------------------------------------------------------
module tb_ram_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] mar;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       lr_n;
    logic       ce_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] wr_sum;
    logic [7:0] rd_sum;

    ram_load_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mar       (mar),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .lr_n      (lr_n),
        .ce_n      (ce_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_sum    (wr_sum),
        .rd_sum    (rd_sum)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // RAM model: write on rising edge while lr_n low, combinational read
    logic [7:0] mem [16];
    logic       fill_req = 1'b0;
    logic [7:0] fill_val = 8'h00;
    int         corrupt_addr = -1;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= fill_val;
        end else if (!lr_n) begin
            mem[mar] <= ram_wdata;
        end
    end

    always_comb begin
        ram_rdata = 8'h00;
        if (!ce_n) begin
            ram_rdata = mem[mar];
            if (int'(mar) == corrupt_addr) ram_rdata[0] = ~ram_rdata[0];
        end
    end

    // Free-running edge counter and per-pass monitor
    int edge_cnt  = 0;
    int s0        = 0;
    int done_cnt  = 0;
    int done_edge = -1;
    int lr_low    = 0;
    int lr_runs   = 0;
    logic prev_lr_n = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        chk("lr_ce_excl", int'(lr_n | ce_n), 1);
        if (done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = edge_cnt - s0;
        end
        if (!lr_n) begin
            lr_low++;
            if (prev_lr_n) lr_runs++;
        end
        prev_lr_n = lr_n;
    end

    logic [7:0] bytes [16];
    int         gaps  [16];

    task automatic fill(input logic [7:0] v);
        @(negedge clk);
        fill_val = v;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    // Pulse start; edge_cnt - s0 counts edges inclusive of the sampling edge
    task automatic start_pass();
        @(posedge clk);
        #1;
        done_cnt  = 0;
        done_edge = -1;
        lr_low    = 0;
        lr_runs   = 0;
        s0        = edge_cnt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_err_clr", int'(err), 0);
    endtask

    // Source driver: inserts gaps[i] idle cycles while ready, before byte i
    task automatic drive(input int n, input bit rand_start);
        int idx = 0;
        int gl;
        int guard = 0;
        bit hs;
        gl = gaps[0];
        while (idx < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (rand_start) start = 1'($urandom_range(0, 1));
            if (wr_ready && gl > 0) begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
                gl--;
            end else begin
                wr_valid = 1'b1;
                wr_data  = bytes[idx];
            end
            hs = wr_valid && wr_ready;
            @(posedge clk);
            if (hs) begin
                idx++;
                if (idx < n) gl = gaps[idx];
            end
        end
        chk("drive_accepted", idx, n);
    endtask

    function automatic int ram_matches(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (mem[i] == bytes[i]) m++;
        return m;
    endfunction

    // Full pass checked against sums taken straight from the byte list
    task automatic run_pass(input string tag, input int corrupt);
        int ws = 0;
        int rs = 0;
        int gsum = 0;
        int g = 0;
        logic [7:0] rb;
        for (int i = 0; i < 16; i++) begin
            ws += int'(bytes[i]);
            rb = bytes[i];
            if (i == corrupt) rb = rb ^ 8'h01;
            rs += int'(rb);
            gsum += gaps[i];
        end
        ws = ws % 256;
        rs = rs % 256;
        corrupt_addr = corrupt;
        fill(8'h5A);
        start_pass();
        drive(16, 1'b0);
        #1;
        wr_valid = 1'b0;
        while (done_cnt == 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        $display("%s: wr_sum=0x%02h rd_sum=0x%02h err=%0d done_edge=%0d",
                 tag, wr_sum, rd_sum, err, done_edge);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_edge"}, done_edge, 65 + gsum);
        chk({tag, "_wr_sum"}, int'(wr_sum), ws);
        chk({tag, "_rd_sum"}, int'(rd_sum), rs);
        chk({tag, "_err"}, int'(err), (ws != rs) ? 1 : 0);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_lr_low"}, lr_low, 16);
        chk({tag, "_lr_runs"}, lr_runs, 16);
        chk({tag, "_ram"}, ram_matches(16), 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int g;
        int ws;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        for (int i = 0; i < 16; i++) gaps[i] = 0;
        #1;
        chk("rst_lr_n", int'(lr_n), 1);
        chk("rst_ce_n", int'(ce_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_outs", int'({mar, ram_wdata, done, err, wr_sum, rd_sum}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Incrementing data, source never stalls
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'(i);
            gaps[i]  = 0;
        end
        run_pass("inc", -1);

        // All-ones data with random source gaps
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'hFF;
            gaps[i]  = int'($urandom_range(0, 3));
        end
        run_pass("ff_gaps", -1);

        // Read path corrupts bit 0 at address 5
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'(i);
            gaps[i]  = 0;
        end
        run_pass("corrupt5", 5);

        // Random data, gaps and corruption point; start must clear the old err
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'($urandom);
            gaps[i]  = int'($urandom_range(0, 2));
        end
        run_pass("rand", int'($urandom_range(0, 16)) - 1);

        // Asynchronous reset in the middle of the write of byte 7
        corrupt_addr = -1;
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'(i);
            gaps[i]  = 0;
        end
        fill(8'hA5);
        start_pass();
        drive(8, 1'b0);
        @(negedge clk);
        chk("pre_rst_lr_n", int'(lr_n), 0);
        rst = 1'b1;
        #1;
        chk("arst_lr_n", int'(lr_n), 1);
        chk("arst_ce_n", int'(ce_n), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_sums", int'({wr_sum, rd_sum}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_resume", int'(busy), 0);
        chk("arst_addr7", int'(mem[7]), 8'hA5);
        chk("arst_addr8", int'(mem[8]), 8'hA5);
        chk("arst_low_addrs", ram_matches(7), 7);
        wr_valid = 1'b0;

        // Abort in the compare cycle of address 3; start toggled while busy
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'($urandom);
            gaps[i]  = 0;
        end
        fill(8'h5A);
        start_pass();
        drive(16, 1'b1);
        #1;
        wr_valid = 1'b0;
        start    = 1'b0;
        seen = 0;
        g = 0;
        // Address 3 appears with ce_n low twice: address cycle, then compare cycle
        while (seen < 2 && g < 100) begin
            @(negedge clk);
            g++;
            if (!ce_n && mar == 4'd3) seen++;
        end
        chk("abort_found_cmp", seen, 2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_ce_n", int'(ce_n), 1);
        chk("abort_lr_n", int'(lr_n), 1);
        repeat (5) @(posedge clk);
        #1;
        ws = 0;
        for (int i = 0; i < 16; i++) ws += int'(bytes[i]);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stay_idle", int'(busy), 0);
        chk("abort_wr_sum", int'(wr_sum), ws % 256);
        chk("abort_rd_sum", int'(rd_sum), (int'(bytes[0]) + int'(bytes[1]) + int'(bytes[2])) % 256);
        chk("abort_err", int'(err), 0);
        chk("abort_ram", ram_matches(16), 16);

        // Recovery after abort
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'($urandom);
            gaps[i]  = int'($urandom_range(0, 3));
        end
        run_pass("recover", -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
